seq_binary_to_bcd_seven_segment: RTL and testbench

//  Sequential, parametrised binary-to-decimal seven-segment driver. It converts a signed or

---
 rtl/seq_binary_to_bcd_seven_segment.sv | 129 ++++++++++++
 tb/tb_seq_binary_to_bcd_seven_segment.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_binary_to_bcd_seven_segment.sv
// Sequential binary-to-decimal seven-segment driver: a one-bit-per-cycle double-dabble
// engine behind a start/busy/done handshake, with sign digit, leading-zero blanking and overflow.
module seq_binary_to_bcd_seven_segment #(
  parameter int IN_WIDTH      = 10,
  parameter int NUM_DIGITS    = 4,
  parameter int SIGNED        = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     binary_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_out
);
  localparam int BCD_DIGITS = NUM_DIGITS - SIGNED;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CW         = $clog2(IN_WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [IN_WIDTH-1:0]     mag_reg;
  logic [BCD_W-1:0]        bcd_reg;
  logic [BCD_W-1:0]        bcd_adj;
  logic                    neg_reg;
  logic                    ovf_sticky;
  logic [CW-1:0]           count_reg;
  logic                    neg_in;
  logic [IN_WIDTH-1:0]     mag_in;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = SEG_BLANK;
    endcase
  endfunction

  // Negation is done in IN_WIDTH bits, so the most negative input maps to 2^(IN_WIDTH-1).
  assign neg_in = (SIGNED != 0) && binary_in[IN_WIDTH-1];
  assign mag_in = neg_in ? ('0 - binary_in) : binary_in;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Display image of the finished BCD register; only sampled on the edge entering DONE.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    seg_next = {NUM_DIGITS{SEG_BLANK}};
    for (int k = BCD_DIGITS - 1; k >= 0; k--) begin
      if (bcd_reg[4*k +: 4] != 4'd0) seen = 1'b1;
      if (ovf_sticky)
        seg_next[7*k +: 7] = SEG_DASH;
      else if ((BLANK_LEADING != 0) && !seen && (k != 0))
        seg_next[7*k +: 7] = SEG_BLANK;
      else
        seg_next[7*k +: 7] = encode(bcd_reg[4*k +: 4]);
    end
    if (SIGNED != 0)
      seg_next[7*(NUM_DIGITS-1) +: 7] = neg_reg ? SEG_DASH : SEG_BLANK;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      seg_out    <= {NUM_DIGITS{SEG_BLANK}};
      mag_reg    <= '0;
      bcd_reg    <= '0;
      neg_reg    <= 1'b0;
      ovf_sticky <= 1'b0;
      count_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            mag_reg    <= mag_in;
            neg_reg    <= neg_in;
            bcd_reg    <= '0;
            ovf_sticky <= 1'b0;
            count_reg  <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_reg == CW'(IN_WIDTH)) begin
            seg_out  <= seg_next;
            overflow <= ovf_sticky;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            // A 1 leaving the top nibble means the value no longer fits in BCD_DIGITS digits.
            {bcd_reg, mag_reg} <= {bcd_adj[BCD_W-2:0], mag_reg, 1'b0};
            if (bcd_adj[BCD_W-1]) ovf_sticky <= 1'b1;
            count_reg <= count_reg + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_binary_to_bcd_seven_segment.sv
// Directed bench for seq_binary_to_bcd_seven_segment: default, no-blanking and
// 8-bit unsigned two-digit instances driven from one linear stimulus sequence.
module tb_seq_binary_to_bcd_seven_segment;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111, SD = 7'b0111111;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [9:0]  bin_a = '0, bin_b = '0;
  logic [7:0]  bin_c = '0;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [27:0] seg_a, seg_b;
  logic [13:0] seg_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_binary_to_bcd_seven_segment dut_a (
    .clock(clk), .resetn(resetn), .start(start_a), .binary_in(bin_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .seg_out(seg_a));

  seq_binary_to_bcd_seven_segment #(.BLANK_LEADING(0)) dut_b (
    .clock(clk), .resetn(resetn), .start(start_b), .binary_in(bin_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .seg_out(seg_b));

  seq_binary_to_bcd_seven_segment #(.IN_WIDTH(8), .NUM_DIGITS(2), .SIGNED(0)) dut_c (
    .clock(clk), .resetn(resetn), .start(start_c), .binary_in(bin_c),
    .busy(busy_c), .done(done_c), .overflow(ovf_c), .seg_out(seg_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge inside the DONE cycle.
  task automatic conv(input int sel, input logic [9:0] val, input int lat);
    int   cycles;
    logic d;
    case (sel)
      0: begin start_a = 1'b1; bin_a = val; end
      1: begin start_b = 1'b1; bin_b = val; end
      default: begin start_c = 1'b1; bin_c = val[7:0]; end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cycles = 0;
    d = 1'b0;
    while (!d && cycles < 60) begin
      @(negedge clk);
      cycles++;
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (cycles == 1)
        check("busy_after_start", (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c, 1'b1);
    end
    check("done_latency", cycles, lat);
  endtask

  initial begin
    int dones;
    int first_done;

    #3 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_ovf", ovf_a, 1'b0);
    check("reset_seg", seg_a, {SB, SB, SB, SB});
    resetn = 1'b1;
    @(negedge clk);

    // Plain positive, negative extremes and zero.
    conv(0, 10'd379, 12);
    check("379_seg", seg_a, {SB, S3, S7, S9});
    check("379_ovf", ovf_a, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done_a, 1'b0);
    check("seg_hold", seg_a, {SB, S3, S7, S9});

    conv(0, 10'h200, 12);
    check("m512_seg", seg_a, {SD, S5, S1, S2});
    check("m512_ovf", ovf_a, 1'b0);
    @(negedge clk);
    conv(0, 10'h3F9, 12);
    check("m7_seg", seg_a, {SD, SB, SB, S7});
    @(negedge clk);
    conv(0, 10'd0, 12);
    check("zero_seg", seg_a, {SB, SB, SB, S0});
    @(negedge clk);
    conv(1, 10'd0, 12);
    check("zero_noblank_seg", seg_b, {SB, S0, S0, S0});
    @(negedge clk);
    conv(1, 10'd42, 12);
    check("42_noblank_seg", seg_b, {SB, S0, S4, S2});
    @(negedge clk);

    // Starts during SHIFT are ignored.
    start_a = 1'b1;
    bin_a = 10'd7;
    @(posedge clk);
    #1 start_a = 1'b0;
    dones = 0;
    first_done = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done_a) begin
        dones++;
        if (first_done == 0) first_done = k;
      end
      start_a = (k == 2 || k == 5);
      bin_a = 10'd500;
    end
    start_a = 1'b0;
    check("ignored_start_dones", dones, 1);
    check("ignored_start_latency", first_done, 12);
    check("ignored_start_seg", seg_a, {SB, SB, SB, S7});

    // Back-to-back: second start is held during the first DONE cycle.
    conv(0, 10'd7, 12);
    check("b2b_first_seg", seg_a, {SB, SB, SB, S7});
    conv(0, 10'd123, 12);
    check("b2b_second_seg", seg_a, {SB, S1, S2, S3});
    @(negedge clk);

    // Reset in the middle of a conversion.
    start_a = 1'b1;
    bin_a = 10'd300;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_busy", busy_a, 1'b0);
    check("midreset_done", done_a, 1'b0);
    check("midreset_seg", seg_a, {SB, SB, SB, SB});
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("midreset_no_done", dones, 0);
    conv(0, 10'd42, 12);
    check("after_reset_42_seg", seg_a, {SB, SB, S4, S2});
    @(negedge clk);

    // Unsigned two-digit instance: overflow and the largest fitting value.
    conv(2, 10'd200, 10);
    check("w8_200_ovf", ovf_c, 1'b1);
    check("w8_200_seg", seg_c, {SD, SD});
    @(negedge clk);
    conv(2, 10'd99, 10);
    check("w8_99_ovf", ovf_c, 1'b0);
    check("w8_99_seg", seg_c, {S9, S9});
    @(negedge clk);
    conv(2, 10'd5, 10);
    check("w8_5_seg", seg_c, {SB, S5});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
